// File: rtl/box_filter.sv
// Moving-average (box) filter over the last FILTER_SIZE unsigned 32-bit samples.
// A sample is pushed on every rising clock edge while rst is high. The window is
// a circular buffer with a running sum. out is registered and holds
// floor(sum / count) including the sample just pushed.
module box_filter #(
    parameter int FILTER_SIZE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in,
    output logic [31:0] out
);

    localparam int CNT_W = $clog2(FILTER_SIZE + 1);
    localparam int PTR_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int SUM_W = 32 + CNT_W;

    logic [31:0]      win [FILTER_SIZE];
    logic [PTR_W-1:0] wptr;
    logic [CNT_W-1:0] count;
    logic [SUM_W-1:0] sum;

    logic             full;
    logic [SUM_W-1:0] evicted;
    logic [SUM_W-1:0] sum_next;
    logic [CNT_W-1:0] count_next;
    logic [SUM_W-1:0] divisor;
    logic [SUM_W-1:0] quotient;
    logic [PTR_W-1:0] wptr_next;

    // Next running sum, fill count, average and write pointer for the sample on in.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        evicted    = '0;
        full       = (count == CNT_W'(FILTER_SIZE));
        if (full) begin
            evicted = {{CNT_W{1'b0}}, win[wptr]};
        end
        // The evicted sample is already part of sum, so this subtraction cannot go negative.
        sum_next   = sum - evicted + SUM_W'(in);
        count_next = full ? count : count + CNT_W'(1);
        // count_next is never 0, so the divisor always lies in 1..FILTER_SIZE.
        divisor    = SUM_W'(count_next);
        quotient   = sum_next / divisor;
        wptr_next  = (wptr == PTR_W'(FILTER_SIZE - 1)) ? '0 : wptr + PTR_W'(1);
    end

    // Push one sample per edge, or clear all history when rst is low.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register updates from pre-edge values.
        if (!rst) begin
            out   <= '0;
            sum   <= '0;
            count <= '0;
            wptr  <= '0;
            // NOTE: window entries are cleared too, so a reset mid-run leaves no stale history behind.
            for (int i = 0; i < FILTER_SIZE; i++) begin
                win[i] <= '0;
            end
        end else begin
            win[wptr] <= in;
            wptr      <= wptr_next;
            count     <= count_next;
            sum       <= sum_next;
            // The mean of unsigned 32-bit samples always fits in 32 bits.
            out       <= quotient[31:0];
        end
    end

endmodule

// File: tb/tb_box_filter.sv
// Self-checking bench for box_filter. Three instances (window sizes 4, 1 and 3)
// share the same stimulus. Expected outputs are queued before each edge and
// compared on the following falling edge.
module tb_box_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_s;
    logic [31:0] out4;
    logic [31:0] out1;
    logic [31:0] out3;

    always #5 clk = ~clk;

    box_filter #(.FILTER_SIZE(4)) dut4 (.clk(clk), .rst(rst), .in(in_s), .out(out4));
    box_filter #(.FILTER_SIZE(1)) dut1 (.clk(clk), .rst(rst), .in(in_s), .out(out1));
    box_filter #(.FILTER_SIZE(3)) dut3 (.clk(clk), .rst(rst), .in(in_s), .out(out3));

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hist[$];
    int          errors = 0;
    int          checks = 0;

    // Floor mean of v plus the most recent samples since reset, limited to n samples.
    function automatic logic [31:0] model_mean(input logic [31:0] v, input int n);
        longint unsigned s = 64'(v);
        longint unsigned k = 1;
        for (int i = hist.size() - 1; i >= 0 && k < longint'(n); i--) begin
            s += 64'(hist[i]);
            k++;
        end
        return 32'(s / k);
    endfunction

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            1:       return out1;
            3:       return out3;
            default: return out4;
        endcase
    endfunction

    task automatic expect_out(input int sel, input logic [31:0] exp, input string tag);
        exp_t e;
        e.sel = sel;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Drive one edge (from a falling edge), then compare everything queued for it.
    task automatic drive_cycle(input logic [31:0] v, input logic r);
        exp_t        e;
        logic [31:0] got;
        in_s = v;
        rst  = r;
        @(posedge clk);
        if (r) hist.push_back(v);
        else   hist.delete();
        @(negedge clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = pick(e.sel);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s (size %0d): got %0d (0x%08h) expected %0d (0x%08h)",
                         e.tag, e.sel, got, got, e.exp, e.exp);
            end
        end
    endtask

    task automatic reset_all(input string tag);
        expect_out(4, 32'd0, tag);
        expect_out(1, 32'd0, tag);
        expect_out(3, 32'd0, tag);
        drive_cycle(32'h0000_1234, 1'b0);
    endtask

    task automatic test_reset();
        // The sample on in during a reset edge is discarded; out is 0.
        reset_all("reset_state");
        reset_all("reset_repeat");
    endtask

    task automatic test_ramp();
        logic [31:0] vals [5] = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd0};
        logic [31:0] exp4 [5] = '{32'd4, 32'd6, 32'd8, 32'd10, 32'd9};
        logic [31:0] exp3 [5] = '{32'd4, 32'd6, 32'd8, 32'd12, 32'd9};
        reset_all("ramp_reset");
        for (int i = 0; i < 5; i++) begin
            expect_out(4, exp4[i], $sformatf("ramp[%0d]", i));
            expect_out(3, exp3[i], $sformatf("ramp[%0d]", i));
            expect_out(1, vals[i], $sformatf("ramp[%0d]", i));
            drive_cycle(vals[i], 1'b1);
        end
    endtask

    task automatic test_truncation();
        logic [31:0] vals [3] = '{32'd1, 32'd2, 32'd2};
        reset_all("trunc_reset");
        for (int i = 0; i < 3; i++) begin
            expect_out(4, 32'd1, $sformatf("trunc[%0d]", i));
            expect_out(3, 32'd1, $sformatf("trunc[%0d]", i));
            drive_cycle(vals[i], 1'b1);
        end
    endtask

    task automatic test_max_value();
        reset_all("max_reset");
        for (int i = 0; i < 5; i++) begin
            expect_out(4, 32'hFFFF_FFFF, $sformatf("max[%0d]", i));
            expect_out(3, 32'hFFFF_FFFF, $sformatf("max[%0d]", i));
            expect_out(1, 32'hFFFF_FFFF, $sformatf("max[%0d]", i));
            drive_cycle(32'hFFFF_FFFF, 1'b1);
        end
    endtask

    task automatic test_mid_reset();
        reset_all("mid_reset_init");
        expect_out(4, 32'd100, "mid_push100");
        drive_cycle(32'd100, 1'b1);
        expect_out(4, 32'd150, "mid_push200");
        drive_cycle(32'd200, 1'b1);
        reset_all("mid_reset_clear");
        expect_out(4, 32'd7, "mid_first_after_reset");
        expect_out(3, 32'd7, "mid_first_after_reset");
        expect_out(1, 32'd7, "mid_first_after_reset");
        drive_cycle(32'd7, 1'b1);
    endtask

    task automatic test_small_sizes();
        logic [31:0] v1 [3] = '{32'd5, 32'd9, 32'd3};
        logic [31:0] v3 [4] = '{32'd3, 32'd6, 32'd9, 32'd12};
        logic [31:0] e3 [4] = '{32'd3, 32'd4, 32'd6, 32'd9};
        reset_all("size1_reset");
        for (int i = 0; i < 3; i++) begin
            expect_out(1, v1[i], $sformatf("size1[%0d]", i));
            drive_cycle(v1[i], 1'b1);
        end
        reset_all("size3_reset");
        for (int i = 0; i < 4; i++) begin
            expect_out(3, e3[i], $sformatf("size3[%0d]", i));
            drive_cycle(v3[i], 1'b1);
        end
    endtask

    task automatic test_hold();
        reset_all("hold_reset");
        expect_out(4, 32'd10, "hold_push10");
        drive_cycle(32'd10, 1'b1);
        expect_out(4, 32'd15, "hold_push20");
        drive_cycle(32'd20, 1'b1);
        // Changing in between edges must not disturb out.
        in_s = 32'hDEAD_BEEF;
        #2;
        checks++;
        if (out4 !== 32'd15) begin
            errors++;
            $display("FAIL hold_between_edges (size 4): got %0d expected 15", out4);
        end
        checks++;
        if (out1 !== 32'd20) begin
            errors++;
            $display("FAIL hold_between_edges (size 1): got %0d expected 20", out1);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        reset_all("random_reset");
        for (int i = 0; i < 1000; i++) begin
            v = 32'($urandom_range(0, 32'h0000_FFFE));
            expect_out(4, model_mean(v, 4), $sformatf("random[%0d]", i));
            expect_out(1, model_mean(v, 1), $sformatf("random[%0d]", i));
            expect_out(3, model_mean(v, 3), $sformatf("random[%0d]", i));
            drive_cycle(v, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b0;
        in_s = 32'd0;
        @(negedge clk);
        test_reset();
        test_ramp();
        test_truncation();
        test_max_value();
        test_mid_reset();
        test_small_sizes();
        test_hold();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
